// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both uart_rx and uart_tx.
//   UART_DATA_BITS  : data bits per frame (8N1 framing)
//   clks_per_bit()  : system clocks per bit, floor(clk_freq / baud)
//   uart_rx_state_e : receiver state encoding
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
//   clk : destination clock
//   rst : asynchronous, active-high reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output, lags d by two clk edges
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q behave as two real
    // flops; blocking ones here would collapse the chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, mid-bit sampling with a per-bit timer.
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   rx_i        : serial line, asynchronous, idle high
//   valid_o     : data_o holds an unconsumed byte
//   data_o      : received byte (LSB first on the line)
//   ready_i     : consumer accepts the byte when valid_o && ready_i
//   frame_err_o : one-cycle pulse, stop bit sampled low
//   overrun_o   : one-cycle pulse, completed byte dropped (holding register full)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int N    = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF = N / 2;
    localparam int TW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [TW-1:0] LAST_FULL = TW'(N - 1);
    localparam logic [TW-1:0] LAST_HALF = TW'(HALF - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    if (N < 4) begin : g_bad_ratio
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    logic           rxs;
    uart_rx_state_e state;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  limit;
    logic           at_sample;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_i),
        .q  (rxs)
    );

    // The start bit is only timed to its middle; every later bit is a full period.
    always_comb begin
        limit = (state == START) ? LAST_HALF : LAST_FULL;
    end

    assign at_sample = (timer == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            // NOTE: a byte loaded at the stop sample below is assigned later in
            // this block, so it overrides this clear within the same edge.
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    if (at_sample) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        // Line back high at mid-start-bit: a glitch, not a frame.
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (at_sample) begin
                        timer   <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STOP: begin
                    if (at_sample) begin
                        timer <= '0;
                        if (rxs) begin
                            // Returning to IDLE at mid-stop-bit leaves half a bit
                            // to catch a back-to-back start edge.
                            state <= IDLE;
                            if (!valid_o || ready_i) begin
                                data_o  <= shreg;
                                valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BREAK: begin
                    // Held-low line reports one framing error, then waits for idle.
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// with expected events queued at issue time and checked by a monitor.
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int N         = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = N / 2;

    typedef enum {EXP_BYTE, EXP_FERR, EXP_OVR, EXP_NONE} exp_kind_e;
    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    exp_t byte_q[$];
    exp_t ferr_q[$];
    exp_t ovr_q[$];

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one frame starting at the current negedge. The expected response
    // lands at E0 + 2 + HALF + 9*N, E0 being the next rising edge.
    // cut >= 0 stops driving after that many bit-clock cycles.
    task automatic issue(input logic [7:0] b, input logic stop, input exp_kind_e k, input int cut);
        logic [9:0] bits;
        int         e0;
        exp_t       e;
        bits   = {stop, b, 1'b0};
        e0     = cyc + 1;
        e.data = b;
        e.cyc  = e0 + 2 + HALF + 9 * N;
        case (k)
            EXP_BYTE: byte_q.push_back(e);
            EXP_FERR: ferr_q.push_back(e);
            EXP_OVR:  ovr_q.push_back(e);
            default:  ;
        endcase
        for (int c = 0; c < 10 * N; c++) begin
            if (cut >= 0 && c == cut) break;
            rx_i = bits[c / N];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares every output event against the queued expectations.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_data;
        exp_t       e;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_quiet", 32'({valid_o, frame_err_o, overrun_o}), 32'd0);
            end else begin
                if (prev_valid && !ready_i) begin
                    check("hold_valid", 32'(valid_o), 32'd1);
                    check("hold_data", 32'(data_o), 32'(prev_data));
                end
                if (valid_o && (!prev_valid || ready_i)) begin
                    check("byte_expected", 32'(byte_q.size() != 0), 32'd1);
                    if (byte_q.size() != 0) begin
                        e = byte_q.pop_front();
                        check("byte_data", 32'(data_o), 32'(e.data));
                        check("byte_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (frame_err_o) begin
                    check("ferr_expected", 32'(ferr_q.size() != 0), 32'd1);
                    if (ferr_q.size() != 0) begin
                        e = ferr_q.pop_front();
                        check("ferr_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (overrun_o) begin
                    check("ovr_expected", 32'(ovr_q.size() != 0), 32'd1);
                    if (ovr_q.size() != 0) begin
                        e = ovr_q.pop_front();
                        check("ovr_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            prev_valid = valid_o;
            prev_data  = data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst     = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        rst = 1'b0;
        idle(5);

        // Single byte.
        issue(8'hA5, 1'b1, EXP_BYTE, -1);
        idle(5);

        // Short low glitch, then a real frame.
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        issue(8'h3C, 1'b1, EXP_BYTE, -1);
        idle(5);

        // Framing error followed by a long break.
        issue(8'h55, 1'b0, EXP_FERR, -1);
        rx_i = 1'b0;
        repeat (40) @(negedge clk);
        idle(5);
        issue(8'h0F, 1'b1, EXP_BYTE, -1);
        idle(5);

        // Backpressure: second byte dropped with an overrun.
        ready_i = 1'b0;
        issue(8'h11, 1'b1, EXP_BYTE, -1);
        issue(8'h22, 1'b1, EXP_OVR, -1);
        check("bp_valid", 32'(valid_o), 32'd1);
        check("bp_data", 32'(data_o), 32'h11);
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(valid_o), 32'd0);
        idle(3);

        // Accept and load on the same edge.
        ready_i = 1'b0;
        issue(8'h11, 1'b1, EXP_BYTE, -1);
        t0 = cyc;
        fork
            issue(8'h22, 1'b1, EXP_BYTE, -1);
            begin
                while (cyc != t0 + 1 + 96) @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
            end
        join
        check("swap_valid", 32'(valid_o), 32'd1);
        check("swap_data", 32'(data_o), 32'h22);

        // Reset in the middle of data bit 4, with a byte still held.
        issue(8'h99, 1'b1, EXP_NONE, 5 * N + HALF);
        rst  = 1'b1;
        rx_i = 1'b1;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_data", 32'(data_o), 32'd0);
        check("arst_flags", 32'({frame_err_o, overrun_o}), 32'd0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        ready_i = 1'b1;
        idle(3);
        issue(8'h00, 1'b1, EXP_BYTE, -1);
        issue(8'hFF, 1'b1, EXP_BYTE, -1);
        idle(5);

        // Random frames, occasional bad stop bit, random idle gaps.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic       stop;
            int         gap;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            issue(b, stop, stop ? EXP_BYTE : EXP_FERR, -1);
            gap = stop ? $urandom_range(0, 12) : $urandom_range(2, 12);
            if (gap > 0) idle(gap);
        end

        idle(30);
        check("left_bytes", 32'(byte_q.size()), 32'd0);
        check("left_ferr", 32'(ferr_q.size()), 32'd0);
        check("left_ovr", 32'(ovr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
